udp_frame_builder: RTL



---
 rtl/eth_pkg.sv | 34 +++
 rtl/udp_frame_builder_if.sv | 39 +++
 rtl/ipv4_csum.sv | 38 +++
 rtl/udp_frame_builder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants and builder state encoding.
// Also hosts the ones-complement fold used by checksum units.
package eth_pkg;

  localparam int ETH_HDR_LEN = 14;
  localparam int IP_HDR_LEN  = 20;
  localparam int UDP_HDR_LEN = 8;
  localparam int HDR_LEN     =
    ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
  localparam int CSUM_WORDS  = IP_HDR_LEN / 2;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_CSUM = 3'd1,
    ST_HDR  = 3'd2,
    ST_KICK = 3'd3,
    ST_SEND = 3'd4
  } state_e;

  // Two folds always suffice for a 20-bit sum of ten words.
  function automatic logic [15:0] csum_fold(
    input logic [19:0] s
  );
    logic [16:0] f1;
    logic [16:0] f2;
    f1 = {1'b0, s[15:0]} + {13'd0, s[19:16]};
    f2 = {1'b0, f1[15:0]} + {16'd0, f1[16]};
    return ~f2[15:0];
  endfunction

endpackage

// File: rtl/udp_frame_builder_if.sv
// Payload stream, BRAM write port and transmitter control
// of the UDP frame builder.
interface udp_frame_builder_if;

  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        bram_wr_en;
  logic [9:0]  bram_wr_addr;
  logic [7:0]  bram_wr_data;
  logic        tx_start;
  logic        tx_busy;
  logic [15:0] ip_id;

  modport master (
    input  s_data,
    input  s_valid,
    input  tx_busy,
    output s_ready,
    output bram_wr_en,
    output bram_wr_addr,
    output bram_wr_data,
    output tx_start,
    output ip_id
  );

  modport slave (
    output s_data,
    output s_valid,
    output tx_busy,
    input  s_ready,
    input  bram_wr_en,
    input  bram_wr_addr,
    input  bram_wr_data,
    input  tx_start,
    input  ip_id
  );

endinterface

// File: rtl/ipv4_csum.sv
// Sequential IPv4 header checksum: one 16-bit word per add.
// Shared by the transmit builder and a future receive checker.
module ipv4_csum
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        add_en_i,
  input  logic [15:0] word_i,
  output logic [19:0] acc_o,
  output logic [15:0] csum_o
);

  logic [19:0] acc_q;
  logic [19:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_en_i) begin
      acc_d = acc_q + {4'd0, word_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o  = acc_q;
  assign csum_o = csum_fold(acc_q);

endmodule

// File: rtl/udp_frame_builder.sv
// Builds one Ethernet/IPv4/UDP frame in the TX BRAM, then
// kicks the transmitter and waits for it to finish.
module udp_frame_builder
  import eth_pkg::*;
#(
  parameter int          PAYLOAD_LEN = 84,
  parameter logic [47:0] MAC_DST = 48'hFFFFFFFFFFFF,
  parameter logic [47:0] MAC_SRC = 48'h020000000001,
  parameter logic [31:0] IP_SRC  = 32'hC0A8010A,
  parameter logic [31:0] IP_DST  = 32'hC0A80101,
  parameter logic [15:0] UDP_SRC = 16'd4000,
  parameter logic [15:0] UDP_DST = 16'd4001,
  parameter logic [7:0]  TTL     = 8'd64
) (
  input logic clk,
  input logic rst_n,
  udp_frame_builder_if.master bus
);

  localparam int CNT_W = $clog2(PAYLOAD_LEN + HDR_LEN);
  localparam int HB    = 8 * HDR_LEN;

  localparam logic [15:0] TOTAL_LEN =
    16'(IP_HDR_LEN + UDP_HDR_LEN + PAYLOAD_LEN);
  localparam logic [15:0] UDP_LEN =
    16'(UDP_HDR_LEN + PAYLOAD_LEN);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             wr_en_q;
  logic             wr_en_d;
  logic [9:0]       wr_addr_q;
  logic [9:0]       wr_addr_d;
  logic [7:0]       wr_data_q;
  logic [7:0]       wr_data_d;
  logic [15:0]      ip_id_q;
  logic [15:0]      ip_id_d;

  logic [15:0]      csum_word;
  logic [15:0]      csum;
  logic [19:0]      csum_acc_unused;

  assign cnt_inc = cnt_q + 1'b1;

  function automatic logic [7:0] hdr_byte(
    input logic [5:0]  idx,
    input logic [15:0] id,
    input logic [15:0] cs
  );
    logic [HB-1:0] v;
    v = {MAC_DST, MAC_SRC, ETHERTYPE_IPV4,
         16'h4500, TOTAL_LEN, id, 16'h4000,
         TTL, IP_PROTO_UDP, cs, IP_SRC, IP_DST,
         UDP_SRC, UDP_DST, UDP_LEN, 16'h0000};
    v = v << (8 * int'(idx));
    return v[HB-1 -: 8];
  endfunction

  // Checksum field itself counts as zero (word 5).
  always_comb begin
    csum_word = 16'h0000;
    case (cnt_q[3:0])
      4'd0: csum_word = 16'h4500;
      4'd1: csum_word = TOTAL_LEN;
      4'd2: csum_word = ip_id_q;
      4'd3: csum_word = 16'h4000;
      4'd4: csum_word = {TTL, IP_PROTO_UDP};
      4'd6: csum_word = IP_SRC[31:16];
      4'd7: csum_word = IP_SRC[15:0];
      4'd8: csum_word = IP_DST[31:16];
      4'd9: csum_word = IP_DST[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  ipv4_csum u_csum (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (state_q == ST_FILL),
    .add_en_i (state_q == ST_CSUM),
    .word_i   (csum_word),
    .acc_o    (csum_acc_unused),
    .csum_o   (csum)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ip_id_d   = ip_id_q;
    case (state_q)
      ST_FILL: begin
        if (bus.s_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = 10'(HDR_LEN) + 10'(cnt_q);
          wr_data_d = bus.s_data;
          if (cnt_q == CNT_W'(PAYLOAD_LEN - 1)) begin
            cnt_d   = '0;
            state_d = ST_CSUM;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_CSUM: begin
        if (cnt_q == CNT_W'(CSUM_WORDS - 1)) begin
          cnt_d     = '0;
          state_d   = ST_HDR;
          wr_en_d   = 1'b1;
          wr_addr_d = 10'd0;
          wr_data_d = hdr_byte(6'd0, ip_id_q, csum);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      // Output register runs one byte ahead of cnt_q.
      ST_HDR: begin
        if (cnt_q == CNT_W'(HDR_LEN - 1)) begin
          cnt_d   = '0;
          state_d = ST_KICK;
        end else begin
          cnt_d     = cnt_inc;
          wr_en_d   = 1'b1;
          wr_addr_d = 10'(cnt_inc);
          wr_data_d = hdr_byte(6'(cnt_inc), ip_id_q, csum);
        end
      end
      ST_KICK: begin
        if (bus.tx_busy) begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!bus.tx_busy) begin
          ip_id_d = ip_id_q + 16'd1;
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FILL;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ip_id_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ip_id_q   <= ip_id_d;
    end
  end

  assign bus.s_ready      = (state_q == ST_FILL);
  assign bus.tx_start     = (state_q == ST_KICK);
  assign bus.bram_wr_en   = wr_en_q;
  assign bus.bram_wr_addr = wr_addr_q;
  assign bus.bram_wr_data = wr_data_q;
  assign bus.ip_id        = ip_id_q;

endmodule
